// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : PC, req/ack program-memory port, one instruction per cycle  |
// | to Decode. Optional FETCH_BOUND_CHECK_EN adds fetch_fault/FAULT state.   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter int ADDR_W     = 16,
  parameter int RESET_PC   = 0,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              global_disable,
  input  logic [31:0]       delta_instruction,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_BOUND_CHECK_EN
  ,
  output logic              fetch_fault
`endif
);

  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
`ifdef FETCH_BOUND_CHECK_EN
    ,
    FAULT = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] exec_pc_q, exec_pc_d;
  logic [15:0]       instruction_q, instruction_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] target;

  assign target = exec_pc_q + delta_instruction[ADDR_W-1:0];

  generate
    if (ADDR_W < 32) begin : g_delta_unused
      logic unused_delta_hi;
      assign unused_delta_hi = ^delta_instruction[31:ADDR_W];
    end
  endgenerate

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(IMEM_DEPTH);
  logic fault_q, fault_d;
  logic pc_ok, target_ok;
  assign pc_ok       = {1'b0, pc_q} < C_DEPTH;
  assign target_ok   = {1'b0, target} < C_DEPTH;
  assign fetch_fault = fault_q;
`else
  logic unused_depth;
  assign unused_depth = ^32'(IMEM_DEPTH);
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    exec_pc_d     = instr_pc_q;
    instruction_d = 16'h0000;
    instr_pc_d    = instr_pc_q;
    imem_req      = 1'b0;
    imem_addr     = pc_q;
`ifdef FETCH_BOUND_CHECK_EN
    fault_d       = fault_q;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
`ifdef FETCH_BOUND_CHECK_EN
        if (!pc_ok) begin
          // An in-range redirect rescues an out-of-range fetch PC.
          if (global_disable && target_ok) begin
            pc_d = target;
          end else begin
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end else
`endif
        begin
          imem_req = 1'b1;
          if (global_disable) begin
            pc_d = target;
            if (!imem_ack) begin
              addr_d  = pc_q;
              state_d = DRAIN;
            end
          end else if (imem_ack) begin
            instruction_d = imem_rdata;
            instr_pc_d    = pc_q;
            pc_d          = pc_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        // Abandoned request must complete at its original address.
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (global_disable) pc_d = target;
        if (imem_ack) state_d = REQ;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= C_RESET_PC;
      addr_q        <= C_RESET_PC;
      exec_pc_q     <= '0;
      instruction_q <= 16'h0000;
      instr_pc_q    <= '0;
`ifdef FETCH_BOUND_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      exec_pc_q     <= exec_pc_d;
      instruction_q <= instruction_d;
      instr_pc_q    <= instr_pc_d;
`ifdef FETCH_BOUND_CHECK_EN
      fault_q       <= fault_d;
`endif
    end
  end

  assign instruction = instruction_q;
  assign instr_pc    = instr_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : table-driven bench with output scoreboard for fetch_unit |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

`ifdef FETCH_BOUND_CHECK_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        global_disable = 1'b0;
  logic [31:0] delta_instruction = 32'h0;
  logic        ack_en = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic [15:0] instr_pc;
  logic        fault_obs;
`ifdef FETCH_BOUND_CHECK_EN
  logic        fetch_fault;
  assign fault_obs = fetch_fault;
`else
  assign fault_obs = 1'b0;
`endif

  logic [15:0] mem [256];
  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = mem[imem_addr[7:0]];

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W(16), .RESET_PC(0), .IMEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .global_disable(global_disable), .delta_instruction(delta_instruction),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_pc(instr_pc)
`ifdef FETCH_BOUND_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  typedef struct {
    logic        ack;
    logic        gd;
    logic [31:0] delta;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        fault;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   step   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic add(input logic ack, input logic gd, input logic [31:0] delta,
                     input logic req, input logic [15:0] addr, input logic [15:0] instr,
                     input logic [15:0] pc, input logic fault);
    vec_t v;
    v.ack = ack; v.gd = gd; v.delta = delta; v.exp_req = req; v.exp_addr = addr;
    v.exp_instr = instr; v.exp_pc = pc; v.exp_fault = fault;
    tbl.push_back(v);
  endtask

  // Called at a negedge; asserts rst mid-cycle and checks the async clear.
  task automatic do_reset();
    #2 rst = 1'b1;
    global_disable = 1'b0;
    ack_en = 1'b1;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_instr", 32'(instruction), 32'h0);
    chk("rst_ipc", 32'(instr_pc), 32'h0);
`ifdef FETCH_BOUND_CHECK_EN
    chk("rst_fault", 32'(fault_obs), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table();
    exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      step = i;
      ack_en = tbl[i].ack;
      global_disable = tbl[i].gd;
      delta_instruction = tbl[i].delta;
      #1;
      chk("imem_req", 32'(imem_req), 32'(tbl[i].exp_req));
      chk("imem_addr", 32'(imem_addr), 32'(tbl[i].exp_addr));
      e.instr = tbl[i].exp_instr;
      e.pc    = tbl[i].exp_pc;
      e.fault = tbl[i].exp_fault;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("instruction", 32'(instruction), 32'(e.instr));
      chk("instr_pc", 32'(instr_pc), 32'(e.pc));
`ifdef FETCH_BOUND_CHECK_EN
      chk("fetch_fault", 32'(fault_obs), 32'(e.fault));
`endif
      @(negedge clk);
    end
    global_disable = 1'b0;
    tbl.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h4000 + 16'(i);
    mem[0] = 16'h2005; mem[1] = 16'h1FC2; mem[2] = 16'h628A;
    @(negedge clk);
    do_reset();
`ifdef FETCH_BOUND_CHECK_EN
    add(1,0,0, 0,16'h0000,16'h0000,16'h0000,0);
    add(1,0,0, 1,16'h0000,16'h2005,16'h0000,0);
    add(1,0,0, 1,16'h0001,16'h1FC2,16'h0001,0);
    add(1,0,0, 1,16'h0002,16'h628A,16'h0002,0);
    add(1,0,0, 1,16'h0003,16'h4003,16'h0003,0);
    add(1,0,0, 0,16'h0004,16'h0000,16'h0003,1);
    add(1,0,0, 0,16'h0004,16'h0000,16'h0003,1);
    add(1,0,0, 0,16'h0004,16'h0000,16'h0003,1);
    run_table();
    do_reset();
    add(1,0,0, 0,16'h0000,16'h0000,16'h0000,0);
    add(1,0,0, 1,16'h0000,16'h2005,16'h0000,0);
    run_table();
`else
    // Zero-wait streaming, then redirect with exec_pc=5, delta=-2.
    add(1,0,0,            0,16'h0000,16'h0000,16'h0000,0);
    add(1,0,0,            1,16'h0000,16'h2005,16'h0000,0);
    add(1,0,0,            1,16'h0001,16'h1FC2,16'h0001,0);
    add(1,0,0,            1,16'h0002,16'h628A,16'h0002,0);
    add(1,0,0,            1,16'h0003,16'h4003,16'h0003,0);
    add(1,0,0,            1,16'h0004,16'h4004,16'h0004,0);
    add(1,0,0,            1,16'h0005,16'h4005,16'h0005,0);
    add(1,0,0,            1,16'h0006,16'h4006,16'h0006,0);
    add(1,1,32'hFFFFFFFE, 1,16'h0007,16'h0000,16'h0006,0);
    add(1,0,0,            1,16'h0003,16'h4003,16'h0003,0);
    add(1,0,0,            1,16'h0004,16'h4004,16'h0004,0);
    run_table();
    do_reset();
    // One wait state, then drains: redirect to 0x20 during a 3-cycle wait,
    // then a second drain where the latest redirect (0x61) wins on the ack cycle.
    add(0,0,0,            0,16'h0000,16'h0000,16'h0000,0);
    add(0,0,0,            1,16'h0000,16'h0000,16'h0000,0);
    add(1,0,0,            1,16'h0000,16'h2005,16'h0000,0);
    add(0,0,0,            1,16'h0001,16'h0000,16'h0000,0);
    add(1,0,0,            1,16'h0001,16'h1FC2,16'h0001,0);
    add(0,0,0,            1,16'h0002,16'h0000,16'h0001,0);
    add(1,0,0,            1,16'h0002,16'h628A,16'h0002,0);
    add(0,1,32'h0000001F, 1,16'h0003,16'h0000,16'h0002,0);
    add(0,0,0,            1,16'h0003,16'h0000,16'h0002,0);
    add(0,0,0,            1,16'h0003,16'h0000,16'h0002,0);
    add(1,0,0,            1,16'h0003,16'h0000,16'h0002,0);
    add(1,0,0,            1,16'h0020,16'h4020,16'h0020,0);
    add(1,0,0,            1,16'h0021,16'h4021,16'h0021,0);
    add(0,1,32'h00000010, 1,16'h0022,16'h0000,16'h0021,0);
    add(1,1,32'h00000040, 1,16'h0022,16'h0000,16'h0021,0);
    add(1,0,0,            1,16'h0061,16'h4061,16'h0061,0);
    run_table();
    do_reset();
    // Redirect to 0xFFFF and wrap back to 0.
    add(1,0,0,            0,16'h0000,16'h0000,16'h0000,0);
    add(1,0,0,            1,16'h0000,16'h2005,16'h0000,0);
    add(1,0,0,            1,16'h0001,16'h1FC2,16'h0001,0);
    add(1,1,32'hFFFFFFFF, 1,16'h0002,16'h0000,16'h0001,0);
    add(1,0,0,            1,16'hFFFF,16'h40FF,16'hFFFF,0);
    add(1,0,0,            1,16'h0000,16'h2005,16'h0000,0);
    run_table();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 16-bit-instruction CPU; the producer end of the Decode `instruction` input and the consumer end of the Execute redirect outputs (`global_disable`, `delta_instruction`).
- Keeps the fetch PC, drives a req/ack program-memory read port and presents one 16-bit instruction (or a 0x0000 NOP bubble) to Decode every cycle.
- Applies Execute branch redirects and discards wrong-path memory responses.

Parameters:
- ADDR_W, 16, width of the halfword-indexed instruction address.
- RESET_PC, 0, halfword address of the first fetch after reset.
- IMEM_DEPTH, 1024, number of valid instruction halfwords (used only by the optional feature).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- global_disable  input  1  from Execute; high for one cycle = taken branch/redirect.
- delta_instruction  input  32  from Execute; signed halfword offset, applied to the PC of the instruction currently in Execute.
- imem_req  output  1  read request to program memory.
- imem_addr  output  ADDR_W  halfword address; held stable while imem_req=1 and imem_ack=0.
- imem_ack  input  1  read data valid this cycle; may be combinational from imem_req (zero wait).
- imem_rdata  input  16  read data, valid when imem_ack=1.
- instruction  output  16  to Decode; registered; 0x0000 = NOP.
- instr_pc  output  ADDR_W  address of the word on `instruction`; registered.
- fetch_fault  output  1  out-of-range fetch flag; present only with FETCH_BOUND_CHECK_EN.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, exec_pc=0.
  - imem_req=0, imem_addr=RESET_PC, instruction=0, instr_pc=0, fetch_fault=0.
- States:
  - IDLE: entered only by reset. First edge with rst=0 -> REQ.
  - REQ: imem_req=1, imem_addr=pc.
  - DRAIN: imem_req=1, imem_addr=old address; waits out an abandoned request.
- REQ, imem_ack=1, no redirect:
  - instruction<=imem_rdata, instr_pc<=pc, pc<=pc+1 (wraps mod 2^ADDR_W).
  - Stays in REQ, so zero-wait memory gives one instruction per cycle.
- REQ, imem_ack=0, no redirect: instruction<=0 (bubble); pc and address hold.
- exec_pc:
  - Updated every edge: exec_pc<=instr_pc. It is the PC of the word now in Execute, since Decode adds one register stage.
  - Bubbles update exec_pc too.
- Redirect (global_disable=1 at an edge):
  - target=exec_pc+delta_instruction[ADDR_W-1:0], wrap mod 2^ADDR_W.
  - instruction<=0 on that edge.
  - The wrong-path word already in Decode is squashed by Execute, not by this block.
- Redirect in REQ:
  - With imem_ack=1 the same cycle: rdata is discarded, pc<=target, stay REQ; next cycle imem_addr=target.
  - With imem_ack=0: pc<=target, go to DRAIN. The address is not changed mid-request.
- DRAIN:
  - instruction<=0 every cycle.
  - On imem_ack=1, discard rdata and go to REQ at pc.
  - A further redirect in DRAIN overwrites pc; the latest redirect wins.
  - A redirect in the same cycle as the draining ack: use the new target, go to REQ.
- Priority: rst > redirect > ack.
- Throughput: taken redirect costs 1 NOP cycle from this block with zero-wait memory. Draining costs the remaining wait states plus 1.

Optional Feature:
- FETCH_BOUND_CHECK_EN defined:
  - Before issuing a request, if pc >= IMEM_DEPTH: fetch_fault<=1 and the block enters FAULT.
  - In FAULT: imem_req=0, instruction=0 every cycle; only rst exits.
  - A redirect in the same cycle as fault detection is taken instead, if its target is in range.
- Not defined: no fetch_fault port, no FAULT state, and the address wraps freely.

Test Plan:
- Zero-wait memory, mem[0..2]=0x2005,0x1FC2,0x628A, release rst -> imem_addr 0,1,2 on consecutive cycles; instruction 0x2005,0x1FC2,0x628A on consecutive edges, instr_pc 0,1,2.
- One wait state (ack every 2nd cycle) -> instruction alternates 0x0000 / mem[n]; imem_addr stable across each wait cycle.
- Redirect with exec_pc=5, delta_instruction=0xFFFFFFFE, zero wait -> next imem_addr=3; one 0x0000 output; then mem[3], mem[4] back-to-back.
- ack held low 3 cycles, redirect to target 0x20 in the first of them -> imem_addr stays at old address until ack; that rdata never appears on instruction; next imem_addr=0x20.
- rst asserted between clock edges during a fetch -> imem_req=0 and instruction=0 immediately, without waiting for an edge; after release, first imem_addr=RESET_PC.
- FETCH_BOUND_CHECK_EN, IMEM_DEPTH=4, sequential run -> addresses 0..3 fetched, then fetch_fault=1, imem_req=0, instruction=0 until rst.
